// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ALU select codes,
// RV32 decode fields and the controller FSM state type.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_ANDN = 3'b010;
  localparam logic [2:0] ALU_SRL1 = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLL1 = 3'b101;
  localparam logic [2:0] ALU_AND  = 3'b110;
  localparam logic [2:0] ALU_ROR1 = 3'b111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_ROR  = 7'b0110000;

  localparam logic [4:0] SHAMT_ONE = 5'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational RV32 decode to the 3-bit ALU select; flags unsupported
// encodings and the shift-by-one immediate forms that ignore rs2.
module alu_instr_decode
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic        o_legal,
  output logic [2:0]  o_sel,
  output logic        o_use_imm
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_shamt;
  logic       w_unused_fields;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign w_shamt  = i_instr[24:20];
  // Register specifiers carry no meaning here; operands arrive as values.
  assign w_unused_fields = ^{i_instr[19:15], i_instr[11:7]};

  always_comb begin
    o_legal   = 1'b0;
    o_sel     = ALU_ADD;
    o_use_imm = 1'b0;
    if (w_opcode == OPC_OP) begin
      if (w_funct7 == F7_BASE) begin
        case (w_funct3)
          F3_ADD_SUB: begin o_legal = 1'b1; o_sel = ALU_ADD; end
          F3_AND:     begin o_legal = 1'b1; o_sel = ALU_AND; end
          F3_XOR:     begin o_legal = 1'b1; o_sel = ALU_XOR; end
          default: ;
        endcase
      end else if (w_funct7 == F7_ALT) begin
        case (w_funct3)
          F3_ADD_SUB: begin o_legal = 1'b1; o_sel = ALU_SUB;  end
          F3_AND:     begin o_legal = 1'b1; o_sel = ALU_ANDN; end
          default: ;
        endcase
      end
    end else if (w_opcode == OPC_OP_IMM && w_shamt == SHAMT_ONE) begin
      if (w_funct3 == F3_SLL && w_funct7 == F7_BASE) begin
        o_legal = 1'b1; o_sel = ALU_SLL1; o_use_imm = 1'b1;
      end else if (w_funct3 == F3_SRL && w_funct7 == F7_BASE) begin
        o_legal = 1'b1; o_sel = ALU_SRL1; o_use_imm = 1'b1;
      end else if (w_funct3 == F3_SRL && w_funct7 == F7_ROR) begin
        o_legal = 1'b1; o_sel = ALU_ROR1; o_use_imm = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for the low-power ALU: accepts one instruction at a
// time, drives operand-isolated ALU inputs and returns the captured result.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_instr,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] op_count
);

  logic             w_legal;
  logic [2:0]       w_sel;
  logic             w_use_imm;
  logic             w_accept;

  state_e           r_state;
  logic             r_req_ready;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_sel;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_illegal;
  logic [CNT_W-1:0] r_op_count;

  alu_instr_decode u_decode (
    .i_instr   (req_instr),
    .o_legal   (w_legal),
    .o_sel     (w_sel),
    .o_use_imm (w_use_imm)
  );

  // r_req_ready is only ever set in IDLE, so it doubles as the state qualifier.
  assign w_accept = req_valid && r_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_req_ready   <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_sel     <= ALU_ADD;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_illegal <= 1'b0;
      r_op_count    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            if (w_legal) begin
              r_alu_a   <= req_rs1;
              r_alu_b   <= w_use_imm ? '0 : req_rs2;
              r_alu_sel <= w_sel;
              r_state   <= ST_EXEC;
            end else begin
              // ALU inputs stay frozen: an illegal op never reaches the datapath.
              r_rsp_data    <= '0;
              r_rsp_illegal <= 1'b1;
              r_rsp_valid   <= 1'b1;
              r_state       <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          r_rsp_data    <= alu_out;
          r_rsp_illegal <= 1'b0;
          r_rsp_valid   <= 1'b1;
          if (r_op_count != {CNT_W{1'b1}})
            r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_sel     = r_alu_sel;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_illegal = r_rsp_illegal;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a behavioural ALU closes the loop,
// directed instructions push hand-computed responses, a monitor pops them.
module tb_alu_issue_ctrl;

  localparam int W  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_instr;
  logic [W-1:0]  req_rs1;
  logic [W-1:0]  req_rs2;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [2:0]    alu_sel;
  logic [W-1:0]  alu_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_illegal;
  logic [CW-1:0] op_count;

  typedef struct packed {
    logic [W-1:0]  data;
    logic          ill;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_instr   (req_instr),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_illegal (rsp_illegal),
    .op_count    (op_count)
  );

  // Behavioural ALU datapath
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      3'b000: alu_out = alu_a + alu_b;
      3'b001: alu_out = alu_a - alu_b;
      3'b010: alu_out = ~alu_a & alu_b;
      3'b011: alu_out = alu_a >> 1;
      3'b100: alu_out = alu_a ^ alu_b;
      3'b101: alu_out = alu_a << 1;
      3'b110: alu_out = alu_a & alu_b;
      default: alu_out = {alu_a[0], alu_a[W-1:1]};
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual=%0h expected=none", rsp_data);
        end else begin
          e = sb_q.pop_front();
          check("rsp_data",    32'(rsp_data),    32'(e.data));
          check("rsp_illegal", 32'(rsp_illegal), 32'(e.ill));
          check("op_count",    32'(op_count),    32'(e.cnt));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic issue(input logic [31:0] instr, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic legal, input logic [W-1:0] exp_a, input logic [W-1:0] exp_b,
                       input logic [2:0] exp_sel, input logic [W-1:0] exp_data,
                       input logic [CW-1:0] exp_cnt);
    exp_t e;
    int   n;
    int   lat;
    e.data = exp_data;
    e.ill  = !legal;
    e.cnt  = exp_cnt;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b1; req_instr = instr; req_rs1 = a; req_rs2 = b;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_ready expected=ready");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("alu_a",   32'(alu_a),   32'(exp_a));
    check("alu_b",   32'(alu_b),   32'(exp_b));
    check("alu_sel", 32'(alu_sel), 32'(exp_sel));
    // lat = index of the first edge after accept at which rsp_valid is seen high
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), legal ? 32'd2 : 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_instr = '0; req_rs1 = '0; req_rs2 = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({rsp_valid, req_ready, rsp_illegal, alu_sel, alu_a, alu_b, rsp_data}), 32'h0);
    check("reset_op_count", 32'(op_count), 32'h0);
    rst_n = 1'b1;

    //     instr         rs1      rs2      lgl  exp_a    exp_b    sel     data     cnt
    issue(32'h003100B3, 4'b1100, 4'b0010, 1'b1, 4'b1100, 4'b0010, 3'b000, 4'b1110, 16'd1); // ADD
    issue(32'h403100B3, 4'b1111, 4'b0001, 1'b1, 4'b1111, 4'b0001, 3'b001, 4'b1110, 16'd2); // SUB
    issue(32'h403170B3, 4'b0011, 4'b0011, 1'b1, 4'b0011, 4'b0011, 3'b010, 4'b0000, 16'd3); // ANDN
    issue(32'h60115093, 4'b1000, 4'b1111, 1'b1, 4'b1000, 4'b0000, 3'b111, 4'b0100, 16'd4); // RORI
    issue(32'h023100B3, 4'b0101, 4'b0011, 1'b0, 4'b1000, 4'b0000, 3'b111, 4'b0000, 16'd4); // MUL
    issue(32'h0020D093, 4'b0110, 4'b0101, 1'b0, 4'b1000, 4'b0000, 3'b111, 4'b0000, 16'd4); // SRLI shamt 2
    issue(32'h00109093, 4'b1011, 4'b0111, 1'b1, 4'b1011, 4'b0000, 3'b101, 4'b0110, 16'd5); // SLLI
    issue(32'h0010D093, 4'b1011, 4'b0111, 1'b1, 4'b1011, 4'b0000, 3'b011, 4'b0101, 16'd6); // SRLI
    issue(32'h003170B3, 4'b1100, 4'b1010, 1'b1, 4'b1100, 4'b1010, 3'b110, 4'b1000, 16'd7); // AND

    // Backpressure with a second request waiting
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(32'h003100B3, 4'b0110, 4'b0011, 1'b1, 4'b0110, 4'b0011, 3'b000, 4'b1001, 16'd8);
    sb_q.push_back('{data: 4'b1100, ill: 1'b0, cnt: 16'd9});
    req_valid = 1'b1; req_instr = 32'h003140B3; req_rs1 = 4'b1010; req_rs2 = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp_data",  32'(rsp_data),  32'h9);
      check("bp_req_ready", 32'(req_ready), 32'h0);
      check("bp_alu_a",     32'(alu_a),     32'h6);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_after_hs_rsp_valid", 32'(rsp_valid), 32'h0);
    check("bp_after_hs_req_ready", 32'(req_ready), 32'h1);
    check("bp_not_yet_accepted",   32'(alu_a),     32'h6);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_second_alu_a",   32'(alu_a),   32'hA);
    check("bp_second_alu_sel", 32'(alu_sel), 32'h4);
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("bp_second_rsp", 32'(rsp_valid), 32'h1);
    n = 0;
    while (rsp_valid && n < 20) begin @(posedge clk); #1; n++; end

    // Reset while an op is in EXEC
    req_valid = 1'b1; req_instr = 32'h003100B3; req_rs1 = 4'b0001; req_rs2 = 4'b0001;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("exec_before_reset_alu_a", 32'(alu_a), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midexec_reset_outputs", 32'({rsp_valid, req_ready, rsp_illegal, alu_sel, alu_a, alu_b, rsp_data}), 32'h0);
    check("midexec_reset_op_count", 32'(op_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_rsp_after_reset", 32'(rsp_valid), 32'h0);
    end
    issue(32'h003100B3, 4'b0101, 4'b0010, 1'b1, 4'b0101, 4'b0010, 3'b000, 4'b0111, 16'd1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the low-power ALU interface: accepts RV32 ALU instructions with operand values over a valid/ready request channel.
- Decodes each instruction to the 3-bit ALU select code and drives registered, operand-isolated inputs to the ALU.
- Captures the ALU result after one execute cycle and returns it on a valid/ready response channel.
- Sits between the issue stage and the ALU. ALU inputs stay frozen whenever no operation is executing, so the ALU datapath does not toggle.

Parameters:
- WIDTH, 4, ALU operand/result width; must match the ALU datapath.
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request valid.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_instr  input  32  RV32 instruction word.
- req_rs1  input  WIDTH  rs1 operand value.
- req_rs2  input  WIDTH  rs2 operand value (ignored for immediate forms).
- alu_a  output  WIDTH  registered ALU operand A.
- alu_b  output  WIDTH  registered ALU operand B.
- alu_sel  output  3  registered ALU select.
- alu_out  input  WIDTH  combinational ALU result.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
- rsp_data  output  WIDTH  captured result; 0 when illegal.
- rsp_illegal  output  1  instruction not supported.
- op_count  output  CNT_W  legal operations retired, saturating.

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is asynchronous and active-low. All outputs reset to 0, FSM to IDLE.
- FSM states: IDLE, EXEC, RESP.
- req_ready = 1 only in IDLE.
- IDLE, accept, legal instruction:
  - load alu_a=req_rs1, alu_b=req_rs2 and alu_sel=decoded code;
  - go to EXEC.
- IDLE, accept, illegal instruction:
  - alu_a/alu_b/alu_sel keep their previous values;
  - rsp_data=0, rsp_illegal=1;
  - go straight to RESP.
- EXEC: lasts exactly one cycle. On exit, rsp_data<=alu_out, rsp_illegal<=0, op_count increments (saturating at all-ones), go to RESP.
- RESP: rsp_valid=1. rsp_data and rsp_illegal are held stable until rsp_ready. On handshake, go to IDLE.
- Timing:
  - legal op accepted at edge T: rsp_valid at T+2;
  - illegal op accepted at edge T: rsp_valid at T+1;
  - minimum 3 cycles per legal op, 2 per illegal op.
- Operand isolation: alu_a/alu_b/alu_sel change only on a legal accept. They never change in EXEC, RESP or IDLE without an accept.
- Decode (all other encodings are illegal):
  - opcode 0110011, funct7 0000000:
    - funct3 000 ADD -> 000;
    - funct3 111 AND -> 110;
    - funct3 100 XOR -> 100.
  - opcode 0110011, funct7 0100000:
    - funct3 000 SUB -> 001;
    - funct3 111 ANDN -> 010 (result = ~rs1 & rs2).
  - opcode 0010011 with shamt (instr[24:20]) = 1, where alu_b is loaded with 0:
    - funct3 001, imm[11:5]=0000000 SLLI -> 101;
    - funct3 101, imm[11:5]=0000000 SRLI -> 011;
    - funct3 101, imm[11:5]=0110000 RORI -> 111.
  - Shift immediates with shamt != 1 are illegal.
- Arithmetic: result is WIDTH bits, wraps modulo 2^WIDTH, no carry/overflow output.
- rst_n asserted mid-EXEC or mid-RESP: the in-flight op is dropped, no response is produced, op_count is not incremented for it.
- req_valid while not in IDLE: ignored (req_ready=0). The requester holds its request.

Decomposition:
- Shared package alu_pkg:
  - ALU select constants ALU_ADD=000, ALU_SUB=001, ALU_ANDN=010, ALU_SRL1=011, ALU_XOR=100, ALU_SLL1=101, ALU_AND=110, ALU_ROR1=111;
  - RV opcode/funct3/funct7 constants;
  - the FSM state enum.
- One natural sub-module: alu_instr_decode. It is combinational: instr -> {legal, sel, use_imm}.

Test Plan:
- ADD 0x003100B3, rs1=1100, rs2=0010 -> rsp_valid 2 cycles after accept, rsp_data=1110, rsp_illegal=0, op_count=1.
- SUB 0x403100B3, rs1=1111, rs2=0001 -> rsp_data=1110. Then ANDN 0x403170B3, rs1=0011, rs2=0011 -> rsp_data=0000.
- RORI 0x60115093, rs1=1000 -> alu_sel=111, alu_b=0000, rsp_data=0100.
- MUL 0x023100B3 -> rsp_valid 1 cycle after accept, rsp_illegal=1, rsp_data=0, alu_a/alu_b/alu_sel unchanged, op_count unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles with a second req_valid pending -> rsp_data stable, req_ready=0. Second op accepted only on the cycle after the response handshake.
- Assert rst_n low during EXEC -> all outputs 0 immediately, no rsp_valid after release, next ADD behaves normally.
